// File: rtl/codeword_checker_if.sv
// codeword_checker_if: handshake and data bundle between the host and the codeword checker.
interface codeword_checker_if;
   logic        start;
   logic [63:0] encoded_msg;
   logic        finish_flag;
   logic        error_flag;
   logic [23:0] syndrome;
   logic [38:0] decoded_msg;
   modport master (output start, encoded_msg, input finish_flag, error_flag, syndrome, decoded_msg);
   modport slave  (input start, encoded_msg, output finish_flag, error_flag, syndrome, decoded_msg);
endinterface

// File: rtl/codeword_checker.sv
// codeword_checker: serial syndrome check of a 63-bit cyclic codeword, one bit per cycle, MSB first.
module codeword_checker #(
   parameter logic [24:0] GENPOLY  = 25'h1DB2777,
   parameter int          CW_BITS  = 63,
   parameter int          MSG_BITS = 39
) (
   input logic               clk,
   input logic               reset,
   codeword_checker_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_n;
   logic                start_d, r63;
   logic [CW_BITS-1:0]  sr;
   logic [MSG_BITS-1:0] msg;
   logic [23:0]         s;
   logic [5:0]          cnt;
   logic                accept;
   assign accept = (state == IDLE) && bus.start && !start_d;
   always_comb begin
      state_n = (state == IDLE)  ? (accept ? SHIFT : IDLE) :
                (state == SHIFT) ? ((cnt == 6'd0) ? DONE : SHIFT) : IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         start_d         <= 1'b0;
         sr              <= '0;
         msg             <= '0;
         s               <= '0;
         cnt             <= '0;
         r63             <= 1'b0;
         bus.finish_flag <= 1'b0;
         bus.error_flag  <= 1'b0;
         bus.syndrome    <= '0;
         bus.decoded_msg <= '0;
      end else begin
         state   <= state_n;
         start_d <= bus.start;
         if (accept) begin
            sr              <= bus.encoded_msg[CW_BITS-1:0];
            msg             <= bus.encoded_msg[CW_BITS-1:24];
            r63             <= bus.encoded_msg[63];
            s               <= '0;
            cnt             <= 6'd62;
            bus.finish_flag <= 1'b0;
         end
         if (state == SHIFT) begin
            // GENPOLY[24] cancels the bit shifted out of s[23], so only the low 24 bits are folded back
            s  <= {s[22:0], sr[CW_BITS-1]} ^ (s[23] ? GENPOLY[23:0] : 24'd0);
            sr <= sr << 1;
            if (cnt != 6'd0) cnt <= cnt - 6'd1;
         end
         if (state == DONE) begin
            bus.syndrome    <= s;
            bus.error_flag  <= (s != 24'd0) | r63;
            bus.decoded_msg <= msg;
            bus.finish_flag <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_codeword_checker.sv
// tb_codeword_checker: randomized and directed checks of codeword_checker against a long-division model.
module tb_codeword_checker;
   localparam logic [24:0] GP = 25'h1DB2777;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   fails = 0;
   codeword_checker_if bus ();
   codeword_checker dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [23:0] ref_syn(input logic [62:0] c);
      logic [62:0] v;
      v = c;
      for (int i = 62; i >= 24; i--) if (v[i]) v = v ^ (63'(GP) << (i - 24));
      return v[23:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_check(input logic [63:0] w);
      bus.encoded_msg = w;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.encoded_msg = {$urandom, $urandom};
   endtask

   task automatic wait_finish(output int cyc);
      cyc = 0;
      while (!bus.finish_flag && cyc < 100) begin
         step();
         cyc++;
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.encoded_msg = '0;
      reset = 1'b1;
      step();
      step();
      checks++;
      if ({bus.finish_flag, bus.error_flag, bus.syndrome, bus.decoded_msg} !== 65'd0) begin
         fails++;
         $display("FAIL reset_outputs: got f=%b e=%b s=%h d=%h want all zero", bus.finish_flag, bus.error_flag, bus.syndrome, bus.decoded_msg);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_vectors();
      logic [63:0] vec [4] = '{64'h0, 64'h0000_0000_01DB_2777, 64'h0000_0000_01DB_2776, 64'h8000_0000_01DB_2777};
      logic [23:0] es  [4] = '{24'h0, 24'h0, 24'h1, 24'h0};
      logic        ee  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [38:0] ed  [4] = '{39'h0, 39'h1, 39'h1, 39'h1};
      int cyc;
      for (int i = 0; i < 4; i++) begin
         start_check(vec[i]);
         checks++;
         if (bus.finish_flag !== 1'b0) begin
            fails++;
            $display("FAIL vec%0d_accept_clears_finish: got %b want 0", i, bus.finish_flag);
         end
         wait_finish(cyc);
         checks++;
         if (cyc !== 64) begin
            fails++;
            $display("FAIL vec%0d_latency: got %0d want 64", i, cyc);
         end
         checks++;
         if ({bus.syndrome, bus.error_flag, bus.decoded_msg} !== {es[i], ee[i], ed[i]}) begin
            fails++;
            $display("FAIL vec%0d_result: got s=%h e=%b d=%h want s=%h e=%b d=%h", i, bus.syndrome, bus.error_flag, bus.decoded_msg, es[i], ee[i], ed[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] w;
      logic [38:0] m;
      logic [23:0] rs;
      int cyc;
      for (int i = 0; i < 10; i++) begin
         m = {$urandom, $urandom};
         w = {($urandom_range(0, 3) == 0), m, 24'd0};
         w[23:0] = (i % 2 == 0) ? ref_syn(w[62:0]) : 24'($urandom);
         rs = ref_syn(w[62:0]);
         start_check(w);
         wait_finish(cyc);
         checks++;
         if (cyc !== 64) begin
            fails++;
            $display("FAIL rand%0d_latency: got %0d want 64", i, cyc);
         end
         checks++;
         if ({bus.syndrome, bus.error_flag, bus.decoded_msg} !== {rs, (rs != 24'd0) | w[63], m}) begin
            fails++;
            $display("FAIL rand%0d_result: word=%h got s=%h e=%b d=%h want s=%h e=%b d=%h", i, w, bus.syndrome, bus.error_flag, bus.decoded_msg, rs, (rs != 24'd0) | w[63], m);
         end
      end
   endtask

   task automatic test_busy_restart();
      logic [63:0] w1 = 64'h0000_1234_5678_9ABC;
      logic [63:0] w2 = 64'h0000_0000_03B6_4EEE;
      int rises = 0, falls = 0, first = 0, cyc;
      logic prev;
      start_check(w1);
      prev = bus.finish_flag;
      for (int k = 1; k <= 200; k++) begin
         bus.start = (k == 10) || (k >= 51);
         step();
         if (bus.finish_flag && !prev) begin
            rises++;
            if (first == 0) first = k;
         end
         if (!bus.finish_flag && prev) falls++;
         prev = bus.finish_flag;
      end
      checks++;
      if (rises !== 1 || falls !== 0) begin
         fails++;
         $display("FAIL busy_single_finish: got rises=%0d falls=%0d want 1 and 0", rises, falls);
      end
      checks++;
      if (first !== 64) begin
         fails++;
         $display("FAIL busy_finish_edge: got %0d want 64", first);
      end
      checks++;
      if (bus.syndrome !== ref_syn(w1[62:0])) begin
         fails++;
         $display("FAIL busy_syndrome: got %h want %h", bus.syndrome, ref_syn(w1[62:0]));
      end
      bus.start = 1'b0;
      step();
      start_check(w2);
      checks++;
      if (bus.finish_flag !== 1'b0) begin
         fails++;
         $display("FAIL busy_rearm_accept: got finish=%b want 0", bus.finish_flag);
      end
      wait_finish(cyc);
      checks++;
      if (cyc !== 64 || bus.syndrome !== ref_syn(w2[62:0]) || bus.decoded_msg !== w2[62:24]) begin
         fails++;
         $display("FAIL busy_rearm_result: got cyc=%0d s=%h d=%h want 64 s=%h d=%h", cyc, bus.syndrome, bus.decoded_msg, ref_syn(w2[62:0]), w2[62:24]);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] w1 = 64'h8000_0000_01DB_2776;
      logic [63:0] w2 = 64'h0000_7FFF_0000_0001;
      int cyc;
      start_check(w1);
      wait_finish(cyc);
      start_check(w2);
      checks++;
      if (bus.finish_flag !== 1'b0 || bus.syndrome !== 24'h1 || bus.error_flag !== 1'b1) begin
         fails++;
         $display("FAIL b2b_accept_hold: got f=%b s=%h e=%b want 0 000001 1", bus.finish_flag, bus.syndrome, bus.error_flag);
      end
      wait_finish(cyc);
      checks++;
      if (cyc !== 64 || bus.syndrome !== ref_syn(w2[62:0]) || bus.decoded_msg !== w2[62:24]) begin
         fails++;
         $display("FAIL b2b_result: got cyc=%0d s=%h d=%h want 64 s=%h d=%h", cyc, bus.syndrome, bus.decoded_msg, ref_syn(w2[62:0]), w2[62:24]);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] w = 64'h0000_0ABC_DEF0_1234;
      int cyc;
      start_check(64'h8000_0000_01DB_2776);
      wait_finish(cyc);
      start_check(w);
      repeat (29) step();
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.finish_flag, bus.error_flag, bus.syndrome, bus.decoded_msg} !== 65'd0) begin
         fails++;
         $display("FAIL midreset_outputs: got f=%b e=%b s=%h d=%h want all zero", bus.finish_flag, bus.error_flag, bus.syndrome, bus.decoded_msg);
      end
      step();
      reset = 1'b0;
      repeat (70) step();
      checks++;
      if (bus.finish_flag !== 1'b0) begin
         fails++;
         $display("FAIL midreset_no_finish: got %b want 0", bus.finish_flag);
      end
      start_check(w);
      wait_finish(cyc);
      checks++;
      if (cyc !== 64 || bus.syndrome !== ref_syn(w[62:0]) || bus.decoded_msg !== w[62:24] || bus.error_flag !== (ref_syn(w[62:0]) != 24'd0)) begin
         fails++;
         $display("FAIL midreset_fresh: got cyc=%0d s=%h e=%b d=%h want 64 s=%h d=%h", cyc, bus.syndrome, bus.error_flag, bus.decoded_msg, ref_syn(w[62:0]), w[62:24]);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_busy_restart();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
